// File: rtl/skeleton_ctrl.sv
// rtl/skeleton_ctrl.sv - host command/response bridge to the skeleton block
// Optional WAIT_RDY watchdog is built only when SKELETON_CTRL_TIMEOUT_EN is defined.
module skeleton_ctrl #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_HEAD = 26,
  parameter int TIMEOUT_CYC   = 1000
) (
  input  logic                                  CLK_SYS,
  input  logic                                  RST,
  input  logic                                  EN,
  input  logic                                  CMD_VALID,
  output logic                                  CMD_READY,
  input  logic [2+BITWIDTH_ADR+BITWIDTH_SYS-1:0] CMD_DATA,
  output logic                                  RSP_VALID,
  input  logic                                  RSP_READY,
  output logic [BITWIDTH_SYS-1:0]               RSP_DATA,
  output logic                                  SKL_RnW,
  output logic [BITWIDTH_ADR-1:0]               SKL_ADR,
  output logic [BITWIDTH_SYS-1:0]               SKL_DATA_IN,
  output logic                                  SKL_TRGG,
  input  logic [BITWIDTH_SYS-1:0]               SKL_DATA_OUT,
  input  logic [BITWIDTH_HEAD-1:0]              SKL_HEAD,
  input  logic                                  SKL_RDY,
  output logic                                  ERR
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WRITE       = 3'd1;
  localparam logic [2:0] S_READ        = 3'd2;
  localparam logic [2:0] S_TRIG        = 3'd3;
  localparam logic [2:0] S_WAIT_FALL   = 3'd4;
  localparam logic [2:0] S_WAIT_RDY    = 3'd5;
  localparam logic [2:0] S_RSP         = 3'd6;
  localparam logic [2:0] S_RSP_HEAD_LO = 3'd7;

  // All-ones is the error code, so the cycle count stops one below it.
  localparam logic [BITWIDTH_SYS-1:0] CNT_MAX = {{(BITWIDTH_SYS-1){1'b1}}, 1'b0};

`ifdef SKELETON_CTRL_TIMEOUT_EN
  localparam logic [BITWIDTH_SYS-1:0] TIMEOUT_VAL = BITWIDTH_SYS'(TIMEOUT_CYC);
`endif

  logic [2:0]                state;
  logic                      alive;
  logic                      err;
  logic                      hdr_pending;
  logic [BITWIDTH_SYS-1:0]   cnt;
  logic [BITWIDTH_SYS-1:0]   cnt_next;
  logic [BITWIDTH_SYS-1:0]   rsp_data;
  logic [BITWIDTH_SYS-1:0]   head_lo;
  logic [BITWIDTH_SYS-1:0]   data_in;
  logic [BITWIDTH_ADR-1:0]   adr;
  logic [2*BITWIDTH_SYS-1:0] head_ext;
  logic [1:0]                cmd_op;
  logic [BITWIDTH_ADR-1:0]   cmd_adr;
  logic [BITWIDTH_SYS-1:0]   cmd_payload;
  logic                      cmd_accept;

  assign cmd_op      = CMD_DATA[2+BITWIDTH_ADR+BITWIDTH_SYS-1 -: 2];
  assign cmd_adr     = CMD_DATA[BITWIDTH_ADR+BITWIDTH_SYS-1 -: BITWIDTH_ADR];
  assign cmd_payload = CMD_DATA[BITWIDTH_SYS-1:0];

  // alive keeps CMD_READY low for the first cycle after reset release.
  assign CMD_READY   = alive && EN && (state == S_IDLE);
  assign cmd_accept  = CMD_VALID && CMD_READY;
  assign RSP_VALID   = (state == S_RSP) || (state == S_RSP_HEAD_LO);
  assign RSP_DATA    = rsp_data;
  assign SKL_RnW     = (state != S_WRITE);
  assign SKL_TRGG    = (state == S_TRIG);
  assign SKL_ADR     = adr;
  assign SKL_DATA_IN = data_in;
  assign ERR         = err;
  assign cnt_next    = (cnt == CNT_MAX) ? cnt : cnt + BITWIDTH_SYS'(1);

  always_comb begin
    head_ext = '0;
    head_ext[BITWIDTH_HEAD-1:0] = SKL_HEAD;
  end

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      alive       <= 1'b0;
      err         <= 1'b0;
      hdr_pending <= 1'b0;
      cnt         <= '0;
      rsp_data    <= '0;
      head_lo     <= '0;
      data_in     <= '0;
      adr         <= '0;
    end else begin
      alive <= 1'b1;
      if (!EN) begin
        state       <= S_IDLE;
        cnt         <= '0;
        hdr_pending <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_accept) begin
              case (cmd_op)
                2'b00: begin
                  state   <= S_WRITE;
                  adr     <= cmd_adr;
                  data_in <= cmd_payload;
                end
                2'b01: begin
                  state <= S_READ;
                  adr   <= cmd_adr;
                end
                2'b10: begin
                  if (SKL_RDY) begin
                    state <= S_TRIG;
                    cnt   <= '0;
                  end else begin
                    state    <= S_RSP;
                    rsp_data <= '1;
                    err      <= 1'b1;
                  end
                end
                default: begin
                  state       <= S_RSP;
                  rsp_data    <= head_ext[2*BITWIDTH_SYS-1:BITWIDTH_SYS];
                  head_lo     <= head_ext[BITWIDTH_SYS-1:0];
                  hdr_pending <= 1'b1;
                end
              endcase
            end
          end
          S_WRITE: state <= S_IDLE;
          S_READ: begin
            rsp_data <= SKL_DATA_OUT;
            state    <= S_RSP;
          end
          S_TRIG: state <= S_WAIT_FALL;
          S_WAIT_FALL: begin
            cnt   <= cnt_next;
            state <= S_WAIT_RDY;
          end
          S_WAIT_RDY: begin
            if (SKL_RDY) begin
              rsp_data <= cnt;
              state    <= S_RSP;
            end
`ifdef SKELETON_CTRL_TIMEOUT_EN
            else if (cnt >= TIMEOUT_VAL) begin
              rsp_data <= '1;
              err      <= 1'b1;
              state    <= S_RSP;
            end
`endif
            else begin
              cnt <= cnt_next;
            end
          end
          S_RSP: begin
            if (RSP_READY) begin
              if (hdr_pending) begin
                state       <= S_RSP_HEAD_LO;
                rsp_data    <= head_lo;
                hdr_pending <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_RSP_HEAD_LO: if (RSP_READY) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_skeleton_ctrl.sv
// tb/tb_skeleton_ctrl.sv - directed self-checking bench for skeleton_ctrl
module tb_skeleton_ctrl;

`ifdef SKELETON_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 20;
`else
  localparam int TO_CYC = 1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        skl_rnw;
  logic [5:0]  skl_adr;
  logic [15:0] skl_data_in;
  logic        skl_trgg;
  logic [15:0] skl_data_out;
  logic [25:0] skl_head;
  logic        skl_rdy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int trgg_cnt = 0;

  skeleton_ctrl #(
    .BITWIDTH_SYS(16), .BITWIDTH_ADR(6), .BITWIDTH_HEAD(26), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK_SYS(clk), .RST(rst), .EN(en),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_DATA(cmd_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .SKL_RnW(skl_rnw), .SKL_ADR(skl_adr), .SKL_DATA_IN(skl_data_in),
    .SKL_TRGG(skl_trgg), .SKL_DATA_OUT(skl_data_out), .SKL_HEAD(skl_head),
    .SKL_RDY(skl_rdy), .ERR(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (skl_trgg === 1'b1) trgg_cnt <= trgg_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rnw"}, skl_rnw, 1);
    check({tag, "_adr"}, skl_adr, 0);
    check({tag, "_data_in"}, skl_data_in, 0);
    check({tag, "_trgg"}, skl_trgg, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Returns #1 after the accepting edge, i.e. in the first cycle of the new state.
  task automatic send_cmd(input logic [1:0] op, input logic [5:0] a, input logic [15:0] p);
    int n = 0;
    @(posedge clk); #1;
    cmd_data  = {op, a, p};
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [15:0] exp, input int hold);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check(tag, rsp_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {rsp_valid, rsp_data}, {1'b1, exp});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [1:0]  wr_op  [2] = '{2'b00, 2'b00};
  logic [5:0]  wr_adr [2] = '{6'h00, 6'h2A};
  logic [15:0] wr_dat [2] = '{16'hA500, 16'h1234};

  initial begin
    int t0;
    int seen;
    rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
    skl_data_out = '0; skl_head = '0; skl_rdy = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_first_cycle", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Writes: one-cycle strobe, data held afterwards, never a response.
    for (int i = 0; i < 2; i++) begin
      send_cmd(wr_op[i], wr_adr[i], wr_dat[i]);
      @(negedge clk);
      check("wr_rnw", skl_rnw, 0);
      check("wr_adr", skl_adr, wr_adr[i]);
      check("wr_data", skl_data_in, wr_dat[i]);
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (c == 0) check("wr_rnw_after", skl_rnw, 1);
        if (rsp_valid) seen++;
      end
      check("wr_no_rsp", seen, 0);
      check("wr_data_held", skl_data_in, wr_dat[i]);
    end

    skl_data_out = 16'hBEEF;
    send_cmd(2'b01, 6'h15, 16'h0000);
    @(negedge clk);
    check("rd_adr", skl_adr, 6'h15);
    check("rd_not_yet", rsp_valid, 0);
    expect_rsp("rd_data", 16'hBEEF, 0);
    @(negedge clk);
    check("rd_done", rsp_valid, 0);

    // Start: skeleton holds RDY low for cycles 1..5 after the trigger cycle.
    t0 = trgg_cnt;
    skl_rdy = 1'b1;
    send_cmd(2'b10, 6'h00, 16'h0000);
    @(negedge clk);
    check("st_trgg_on", skl_trgg, 1);
    @(posedge clk); #1 skl_rdy = 1'b0;
    @(negedge clk);
    check("st_trgg_off", skl_trgg, 0);
    repeat (5) @(posedge clk);
    #1 skl_rdy = 1'b1;
    expect_rsp("st_count", 16'h0005, 0);
    check("st_one_pulse", trgg_cnt - t0, 1);
    check("st_no_err", err, 0);

    skl_head = 26'h1041108;
    send_cmd(2'b11, 6'h00, 16'h0000);
    skl_head = 26'h3FFFFFF;
    expect_rsp("head_hi", 16'h0104, 3);
    expect_rsp("head_lo", 16'h1108, 0);
    @(negedge clk);
    check("head_done", rsp_valid, 0);

    t0 = trgg_cnt;
    skl_rdy = 1'b0;
    send_cmd(2'b10, 6'h00, 16'h0000);
    expect_rsp("busy_rsp", 16'hFFFF, 0);
    check("busy_no_trgg", trgg_cnt - t0, 0);
    check("busy_err", err, 1);

    en = 1'b0;
    @(negedge clk);
    check("en_low_ready", cmd_ready, 0);
    @(posedge clk); #1 en = 1'b1;

    skl_rdy = 1'b1;
    send_cmd(2'b10, 6'h00, 16'h0000);
    @(posedge clk); #1 skl_rdy = 1'b0;
`ifdef SKELETON_CTRL_TIMEOUT_EN
    expect_rsp("timeout_rsp", 16'hFFFF, 0);
    check("timeout_err", err, 1);
    skl_rdy = 1'b1;
    send_cmd(2'b10, 6'h00, 16'h0000);
    @(posedge clk); #1 skl_rdy = 1'b0;
    repeat (8) @(posedge clk);
`else
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_timeout", seen, 0);
`endif

    // Reset while waiting for RDY: aborted silently, next read served normally.
    @(posedge clk); #1 rst = 1'b1;
    skl_rdy = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);
    check("mid_rst_ready", cmd_ready, 1);
    skl_data_out = 16'h5A5A;
    send_cmd(2'b01, 6'h3C, 16'h0000);
    @(negedge clk);
    check("rd2_adr", skl_adr, 6'h3C);
    expect_rsp("rd2_data", 16'h5A5A, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
